mem_fill_responder: RTL
=======================

# mem_fill_responder

Memory-side responder for the cache miss/fill interface. It accepts one request at a time from a cache controller (I-cache or D-cache side of the arbiter): either a block read that returns an 8-word cache line, or a single-word write-through. After a fixed access latency it streams the line back one word per cycle, each word tagged with its byte address and a last flag. It sits behind the cache/memory arbiter and holds the word-addressed backing store.

## Interface

Parameters:
- `LATENCY`, default 4: cycles from request acceptance to the first response word or `wr_done`; legal range 1..15.
- `BLOCK_WORDS`, default 8: words per line; fixed at 8 (16-byte line).
- `MEM_AW`, default 15: word-index width of the backing array (2^MEM_AW words of 16 bits).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present; the initiator holds it and all `req_*` fields stable until accepted.
- `req_ready` out 1: block is idle and can accept a request. Acceptance is `req_valid & req_ready` at a rising edge.
- `req_wr` in 1: 1 = single-word write; 0 = block read.
- `req_addr` in 16: byte address. Reads use the line base `{req_addr[15:4],4'h0}`. Writes use word `req_addr[15:1]`. Bit 0 is ignored.
- `req_wdata` in 16: write data.
- `rsp_valid` out 1: one-cycle strobe per returned read word.
- `rsp_data` out 16: returned word.
- `rsp_addr` out 16: byte address of `rsp_data`.
- `rsp_last` out 1: high with the 8th word of a line.
- `wr_done` out 1: one-cycle pulse when the write completes.
- `busy` out 1: the inverse of `req_ready`.

## Operation

- FSM states: IDLE, WAIT, STREAM, WDONE.
- IDLE: `req_ready`=1. On acceptance:
  - Latch the request.
  - Load the latency counter with LATENCY-1.
  - Go to WAIT, or directly to STREAM/WDONE when LATENCY=1.
- WAIT: decrement the counter each cycle. When it reaches 0, go to STREAM (read) or WDONE (write).
- Write commit: the array word `req_addr[MEM_AW:1]` is written on the acceptance edge itself. A later read therefore always sees it.
- STREAM:
  - Word counter i runs 0..7.
  - Each cycle: `rsp_valid`=1, `rsp_addr` = base + 2·i, `rsp_data` = array[(base>>1)+i].
  - `rsp_last` is high when i=7, after which the FSM returns to IDLE.
  - Order is always offset 0→7; there is no critical-word-first.
- WDONE: `wr_done`=1 for one cycle, then IDLE.
- Address arithmetic:
  - `rsp_addr` is 16-bit; the line base is 16-byte aligned, so the offset never carries out of bits [3:0].
  - Line 0xFFF0 returns addresses 0xFFF0..0xFFFE with no wrap.
  - Array index = byte address bits [MEM_AW:1]; higher bits are discarded, so addresses alias modulo 2^(MEM_AW+1) bytes.
- Only one request is outstanding. `req_valid` while busy is ignored and not queued; the initiator keeps holding it.
- The backing array is not reset. Contents are undefined unless preloaded by the bench.

## Timing

- Reset values (asynchronous, while `rst_n`=0):
  - FSM = IDLE, so `req_ready`=1 and `busy`=0.
  - `rsp_valid`, `rsp_last`, `wr_done` = 0.
  - `rsp_data` and `rsp_addr` = 0.
  - Counters = 0.
- Read accepted at edge T:
  - Word i is presented in the cycle following edge T+LATENCY−1+i.
  - With LATENCY=4: `rsp_valid` is high in cycles T+4..T+11; `rsp_last` is in cycle T+11.
  - `req_ready` returns to 1 in cycle T+12.
- Write accepted at edge T: `wr_done` is high in cycle T+LATENCY and `req_ready` is 1 in cycle T+LATENCY+1.
- Back-to-back: a request held during busy is accepted at the first edge where `req_ready`=1. There are no idle cycles beyond that.
- Outputs are registered; there is no combinational path from `req_*` to `rsp_*`. The one exception is `req_ready`, which is a state decode.
- Reset asserted mid-WAIT or mid-STREAM:
  - The transfer aborts immediately and all strobes drop.
  - No further words and no `wr_done` are produced.
  - A write already committed at acceptance stays in the array.

## Test plan

- Reset:
  - Assert `rst_n`=0 mid-cycle with random inputs → all outputs take their reset values asynchronously, with `req_ready`=1.
  - Release → no `rsp_valid` or `wr_done` until a request is accepted.
- Write then read:
  - Write 0xBEEF to 0x0012, accepted at T → `wr_done` only in cycle T+4.
  - Read at 0x001A → 8 words in cycles T'+4..T'+11.
  - `rsp_addr` runs 0x0010..0x001E.
  - The word with `rsp_addr`=0x0012 has `rsp_data`=0xBEEF.
  - `rsp_last` is high only on 0x001E.
- Back-to-back hold: issue a second read while the first streams; hold `req_valid` → accepted exactly in the cycle after `rsp_last`, and no response overlap.
- Mid-stream reset: assert `rst_n` after the 3rd word → `rsp_valid` drops immediately; after release, a new read returns a full clean line starting at offset 0.
- Top-of-memory and alias:
  - With MEM_AW=10, write 0x1234 to 0x0802 → a read of line 0x0800 and a read of line 0x0000 both return 0x1234 at offset 1.
  - A read of line 0xFFF0 ends at `rsp_addr`=0xFFFE.
- LATENCY=1 build: read accepted at T → first `rsp_valid` in cycle T+1, `rsp_last` in cycle T+8.

Source files
------------

// File: rtl/mem_fill_responder_if.sv
// Cache miss/fill request and line-response bundle between an arbiter-side
// initiator (master) and the memory responder (slave).
interface mem_fill_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [15:0] rsp_addr;
  logic        rsp_last;
  logic        wr_done;
  logic        busy;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, wr_done, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, wr_done, busy
  );
endinterface

// File: rtl/mem_fill_responder.sv
// Memory-side responder: single outstanding line read (8 words streamed after
// a fixed latency) or single-word write-through, backed by a word array.
module mem_fill_responder #(
  parameter int LATENCY     = 4,
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_AW      = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_fill_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, STREAM, WDONE} state_t;

  localparam logic [2:0] LAST_IDX = 3'(BLOCK_WORDS - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [2:0]  idx, idx_nx;
  logic [11:0] line, line_nx;
  logic        wr, wr_nx;
  logic        accept;
  logic        addr_lsb_unused;

  logic [MEM_AW-1:0] wr_idx;
  logic [MEM_AW-1:0] rd_idx;
  logic [15:0]       mem [0:(1<<MEM_AW)-1];

  assign accept          = bus.req_valid & bus.req_ready;
  assign addr_lsb_unused = bus.req_addr[0];
  assign bus.req_ready   = (state == IDLE);
  assign bus.busy        = (state != IDLE);

  // Word index: byte-address bits above MEM_AW are dropped, so the store aliases.
  assign wr_idx = MEM_AW'(bus.req_addr[15:1]);
  assign rd_idx = MEM_AW'({line_nx, idx_nx});

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    line_nx  = line;
    wr_nx    = wr;
    case (state)
      IDLE: begin
        if (accept) begin
          wr_nx   = bus.req_wr;
          line_nx = bus.req_addr[15:4];
          idx_nx  = 3'd0;
          if (LATENCY == 1) begin
            cnt_nx   = 4'd0;
            state_nx = bus.req_wr ? WDONE : STREAM;
          end else begin
            cnt_nx   = 4'(LATENCY - 1);
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = wr ? WDONE : STREAM;
      end
      STREAM: begin
        if (idx == LAST_IDX) begin
          state_nx = IDLE;
          idx_nx   = 3'd0;
        end else begin
          idx_nx = idx + 3'd1;
        end
      end
      WDONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Write-through commits on the acceptance edge, ahead of the wr_done strobe.
  always_ff @(posedge clk) begin
    if (accept && bus.req_wr) mem[wr_idx] <= bus.req_wdata;
  end

  // Outputs are registered from the next-state decode so each strobe lines up
  // with the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      idx           <= 3'd0;
      line          <= 12'd0;
      wr            <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_last  <= 1'b0;
      bus.wr_done   <= 1'b0;
      bus.rsp_addr  <= 16'd0;
      bus.rsp_data  <= 16'd0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      idx           <= idx_nx;
      line          <= line_nx;
      wr            <= wr_nx;
      bus.rsp_valid <= (state_nx == STREAM);
      bus.rsp_last  <= (state_nx == STREAM) && (idx_nx == LAST_IDX);
      bus.wr_done   <= (state_nx == WDONE);
      if (state_nx == STREAM) begin
        bus.rsp_addr <= {line_nx, idx_nx, 1'b0};
        bus.rsp_data <= mem[rd_idx];
      end
    end
  end

endmodule
